// File: rtl/shake_pkg.sv
// Shared definitions for the SHAKE absorb-side packer: rates, pad bytes,
// FSM state codes, the AXIS beat payload and rate helpers.
// DATA_W (64) and BLK_W (1344, the SHAKE128 rate) are fixed for this block.
package shake_pkg;

  localparam int unsigned DATA_W    = 64;
  localparam int unsigned KEEP_W    = DATA_W / 8;
  localparam int unsigned BLK_W     = 1344;
  localparam int unsigned RATE128_B = 168;
  localparam int unsigned RATE256_B = 136;
  localparam int unsigned WCNT_W    = 5;
  localparam int unsigned OFF_W     = 8;

  localparam logic [7:0] PAD_DS  = 8'h1F;
  localparam logic [7:0] PAD_END = 8'h80;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_FILL    = 2'd1;
  localparam logic [1:0] ST_PADONLY = 2'd2;
  localparam logic [1:0] ST_HAND    = 2'd3;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [KEEP_W-1:0] keep;
    logic              last;
  } axis_beat_t;

  // Words per absorb block; only mode bit 0 selects the rate.
  function automatic logic [WCNT_W-1:0] rate_words(input logic [1:0] mode);
    return ((mode & 2'b01) != 2'b00) ? WCNT_W'(RATE256_B / 8) : WCNT_W'(RATE128_B / 8);
  endfunction

  // Bytes per absorb block.
  function automatic logic [OFF_W-1:0] rate_bytes(input logic [1:0] mode);
    return {rate_words(mode), 3'b000};
  endfunction

endpackage

// File: rtl/shake_pad_insert.sv
// Combinational SHAKE pad insertion for the block holding the final beat.
// Ports:
//   blk_i    - block with the tlast word already merged (unmasked)
//   e_i      - message end offset within the block (bytes), e_i < R
//   rate_b_i - rate R in bytes (136 or 168)
//   keep_i   - tkeep of the tlast beat (contiguous low-byte mask)
//   blk_o    - block with dead lanes zeroed and 0x1F / 0x80 applied
// Message byte i lives at bits [8(R-1-i)+7 : 8(R-1-i)].
module shake_pad_insert
  import shake_pkg::*;
(
  input  logic [BLK_W-1:0]  blk_i,
  input  logic [OFF_W-1:0]  e_i,
  input  logic [OFF_W-1:0]  rate_b_i,
  input  logic [KEEP_W-1:0] keep_i,
  output logic [BLK_W-1:0]  blk_o
);

  // First byte offset of the tlast word.
  logic [OFF_W-1:0] base_c;
  assign base_c = e_i - OFF_W'($countones(keep_i));

  // Both layouts are unrolled separately so every byte select is constant.
  always_comb begin
    blk_o = blk_i;
    if (rate_b_i == OFF_W'(RATE256_B)) begin
      for (int i = 0; i < RATE256_B; i++) begin
        if ((OFF_W'(i) - base_c) < OFF_W'(8) && !keep_i[3'(OFF_W'(i) - base_c)])
          blk_o[8*(RATE256_B-1-i) +: 8] = 8'h00;
        if (OFF_W'(i) == e_i)
          blk_o[8*(RATE256_B-1-i) +: 8] = blk_o[8*(RATE256_B-1-i) +: 8] ^ PAD_DS;
      end
    end else begin
      for (int i = 0; i < RATE128_B; i++) begin
        if ((OFF_W'(i) - base_c) < OFF_W'(8) && !keep_i[3'(OFF_W'(i) - base_c)])
          blk_o[8*(RATE128_B-1-i) +: 8] = 8'h00;
        if (OFF_W'(i) == e_i)
          blk_o[8*(RATE128_B-1-i) +: 8] = blk_o[8*(RATE128_B-1-i) +: 8] ^ PAD_DS;
      end
    end
    // Byte R-1 sits at the bottom of the vector in both layouts; if e == R-1
    // it already holds 0x1F and becomes 0x9F.
    blk_o[7:0] = blk_o[7:0] ^ PAD_END;
  end

endmodule

// File: rtl/shake_fifo_read.sv
// AXI4-Stream slave that packs 64-bit message words into SHAKE absorb
// blocks, applies SHAKE multi-rate padding and tags the final block.
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   SHA3_start        - pulse: latch mode, (re)start a message
//   mode[1:0]         - bit0: 1=SHAKE256 (R=136 B), 0=SHAKE128 (R=168 B)
//   s_axis_*          - AXIS slave (tdata byte 0 first, tkeep on tlast only)
//   block             - packed block, message byte i at bits 8(R-1-i)+:8
//   block_valid/ready - single-buffer handshake toward the core
//   is_last           - qualifies block_valid: final padded block
//   busy              - high from SHA3_start until the final block is taken
module shake_fifo_read
  import shake_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              SHA3_start,
  input  logic [1:0]        mode,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic [KEEP_W-1:0] s_axis_tkeep,
  input  logic              s_axis_tlast,
  output logic [BLK_W-1:0]  block,
  output logic              block_valid,
  input  logic              block_ready,
  output logic              is_last,
  output logic              busy
);

  logic [1:0]        state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [WCNT_W-1:0] word_cnt_q, word_cnt_d;
  logic [BLK_W-1:0]  block_q, block_d;
  logic              valid_q, valid_d;
  logic              is_last_q, is_last_d;
  logic              busy_q, busy_d;
  logic              tready_q, tready_d;
  logic              pad_pend_q, pad_pend_d;

  axis_beat_t        beat;
  logic              beat_c;
  logic [WCNT_W-1:0] rate_w_c;
  logic [OFF_W-1:0]  rate_b_c;
  logic [OFF_W-1:0]  end_off_c;
  logic [BLK_W-1:0]  blk_wr_c;
  logic [BLK_W-1:0]  blk_pad_c;
  logic [BLK_W-1:0]  pad_only_c;

  assign beat      = '{data: s_axis_tdata, keep: s_axis_tkeep, last: s_axis_tlast};
  assign beat_c    = s_axis_tvalid && tready_q;
  assign rate_w_c  = rate_words(mode_q);
  assign rate_b_c  = rate_bytes(mode_q);
  assign end_off_c = {word_cnt_q, 3'b000} + OFF_W'($countones(beat.keep));

  // Current beat dropped into the byte lanes selected by word_cnt.
  always_comb begin
    blk_wr_c = block_q;
    if (mode_q[0]) begin
      for (int i = 0; i < RATE256_B; i++) begin
        if (WCNT_W'(i / 8) == word_cnt_q)
          blk_wr_c[8*(RATE256_B-1-i) +: 8] = beat.data[8*(i%8) +: 8];
      end
    end else begin
      for (int i = 0; i < RATE128_B; i++) begin
        if (WCNT_W'(i / 8) == word_cnt_q)
          blk_wr_c[8*(RATE128_B-1-i) +: 8] = beat.data[8*(i%8) +: 8];
      end
    end
  end

  // Block sent after a message that ended exactly on the rate boundary.
  always_comb begin
    pad_only_c      = '0;
    pad_only_c[7:0] = PAD_END;
    if (mode_q[0]) pad_only_c[8*(RATE256_B-1) +: 8] = PAD_DS;
    else           pad_only_c[8*(RATE128_B-1) +: 8] = PAD_DS;
  end

  shake_pad_insert u_pad (
    .blk_i    (blk_wr_c),
    .e_i      (end_off_c),
    .rate_b_i (rate_b_c),
    .keep_i   (beat.keep),
    .blk_o    (blk_pad_c)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state and registered-output next values.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    word_cnt_d = word_cnt_q;
    block_d    = block_q;
    is_last_d  = is_last_q;
    pad_pend_d = pad_pend_q;

    if (SHA3_start) begin
      // Restart from any state; a pending block is abandoned.
      state_d    = ST_FILL;
      mode_d     = mode;
      word_cnt_d = '0;
      block_d    = '0;
      is_last_d  = 1'b0;
      pad_pend_d = 1'b0;
    end else begin
      case (state_q)
        ST_FILL: begin
          if (beat_c) begin
            if (beat.last) begin
              if (end_off_c < rate_b_c) begin
                block_d   = blk_pad_c;
                is_last_d = 1'b1;
              end else begin
                // Exact fill: data block now, pad-only block after it.
                block_d    = blk_wr_c;
                is_last_d  = 1'b0;
                pad_pend_d = 1'b1;
              end
              state_d = ST_HAND;
            end else if (word_cnt_q == rate_w_c - WCNT_W'(1)) begin
              block_d   = blk_wr_c;
              is_last_d = 1'b0;
              state_d   = ST_HAND;
            end else begin
              block_d    = blk_wr_c;
              word_cnt_d = word_cnt_q + WCNT_W'(1);
            end
          end
        end
        ST_PADONLY: begin
          block_d   = pad_only_c;
          is_last_d = 1'b1;
          state_d   = ST_HAND;
        end
        ST_HAND: begin
          if (block_ready && valid_q) begin
            if (is_last_q) begin
              state_d   = ST_IDLE;
              is_last_d = 1'b0;
            end else if (pad_pend_q) begin
              state_d    = ST_PADONLY;
              pad_pend_d = 1'b0;
            end else begin
              state_d    = ST_FILL;
              block_d    = '0;
              word_cnt_d = '0;
            end
          end
        end
        default: ;
      endcase
    end

    tready_d = (state_d == ST_FILL);
    valid_d  = (state_d == ST_HAND);
    busy_d   = (state_d != ST_IDLE);
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q     <= '0;
      word_cnt_q <= '0;
      block_q    <= '0;
      valid_q    <= 1'b0;
      is_last_q  <= 1'b0;
      busy_q     <= 1'b0;
      tready_q   <= 1'b0;
      pad_pend_q <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      word_cnt_q <= word_cnt_d;
      block_q    <= block_d;
      valid_q    <= valid_d;
      is_last_q  <= is_last_d;
      busy_q     <= busy_d;
      tready_q   <= tready_d;
      pad_pend_q <= pad_pend_d;
    end
  end

  assign s_axis_tready = tready_q;
  assign block         = block_q;
  assign block_valid   = valid_q;
  assign is_last       = is_last_q;
  assign busy          = busy_q;

endmodule

// File: doc/shake_fifo_read.md
Name: shake_fifo_read

Overview:
- AXI4-Stream slave that takes message/seed words from the DMA FIFO and packs them into rate-sized absorb blocks for the SHA3/SHAKE core.
- Applies SHAKE multi-rate padding and tags the final block.
- Input-side counterpart of the SHAKE output streamer; uses the same mode encoding (mode[0]=1 SHAKE256, mode[0]=0 SHAKE128) and the same block bit layout.

Parameters:
- DATA_W, 64, AXIS data width; fixed, listed for documentation only.
- BLK_W, 1344, absorb block width (SHAKE128 rate).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- SHA3_start  in  1  one-cycle pulse; latches mode and starts a new message
- mode  in  2  bit0: 1=SHAKE256 (R=136 B, 17 words), 0=SHAKE128 (R=168 B, 21 words); bit1 unused
- s_axis_tvalid  in  1  AXIS valid
- s_axis_tready  out  1  AXIS ready
- s_axis_tdata  in  64  AXIS data; byte k = tdata[8k+7:8k], byte 0 first in message order
- s_axis_tkeep  in  8  contiguous low-byte mask; meaningful only when tlast=1, otherwise 8'hFF required
- s_axis_tlast  in  1  last beat of message
- block  out  1344  packed block; message byte i at bits [8(R-1-i)+7 : 8(R-1-i)]; bits >= 8R are zero
- block_valid  out  1  block ready for core
- block_ready  in  1  core accepts block
- is_last  out  1  qualifies block_valid: final, padded block
- busy  out  1  high from SHA3_start until the final block is accepted

Behaviour:
- Reset (async) values: s_axis_tready=0, block=0, block_valid=0, is_last=0, busy=0, state=IDLE, counters=0.
- States:
  - IDLE → FILL on SHA3_start. Latch mode, clear block, word_cnt=0.
  - FILL: tready=1. Each accepted beat writes 8 bytes at byte offset 8*word_cnt, then word_cnt++.
  - FILL, non-last beat with word_cnt reaching R/8 → HAND with is_last=0.
  - FILL, tlast beat: n = popcount(tkeep), 1..8. End offset e = 8*word_cnt + n.
    - e < R → insert pad in the same cycle, go to HAND with is_last=1.
    - e == R (tlast beat fills the block exactly) → HAND with is_last=0, then PADONLY.
  - PADONLY: block cleared with byte0 = 8'h1F and byte R-1 = 8'h80 → HAND with is_last=1. Takes one cycle; tready=0.
  - HAND: tready=0; block_valid=1; block and is_last held stable. On block_ready & block_valid:
    - is_last=1 → IDLE, busy=0.
    - is_last=0 and the block came from the e == R case → PADONLY.
    - otherwise → FILL with block cleared and word_cnt=0.
- Padding: byte e ^= 8'h1F, byte R-1 ^= 8'h80. When e == R-1 the byte is 8'h9F. Bytes of the tlast word above n are forced to zero before padding.
- Latency: block_valid rises the cycle after the completing beat is accepted. No beat is accepted while block_valid=1 (single block buffer).
- Empty message (SHA3_start followed immediately by a tlast beat with tkeep=0): treated as n=0, producing the pad-only block.
- SHA3_start in any non-IDLE state aborts the current message and restarts in FILL with the new mode. A pending block_valid is dropped that cycle.
- tvalid in IDLE is ignored (tready=0).
- block_ready without block_valid is ignored.
- All block writes are byte-lane selects computed from word_cnt (5 bits, max 20).

Decomposition:
- Shared package shake_pkg:
  - RATE128_B=168, RATE256_B=136
  - PAD_DS=8'h1F, PAD_END=8'h80
  - state encoding IDLE/FILL/PADONLY/HAND
  - rate_words(mode) function
- One sub-module: shake_pad_insert (combinational). Takes the block, e, R and tkeep; returns the masked, padded block. Keeps the FSM file readable.

Test Plan:
- SHAKE256, 32-byte seed (4 beats, tlast beat tkeep=FF) → one block, is_last=1; byte32=1F, byte135=80, bits[1343:1088]=0; block_valid one cycle after beat 4.
- SHAKE256, 135 bytes (17 beats, last tkeep=7F) → single block, byte135=9F, is_last=1.
- SHAKE256, 136 bytes (17 beats, last tkeep=FF) → two blocks: first is_last=0 with data; second is_last=1, byte0=1F, byte135=80, all other bytes 0.
- SHAKE128, 34 bytes (5 beats, last tkeep=03) → byte34=1F, byte167=80; hold block_ready=0 for 5 cycles → tready=0 and block stable throughout, busy drops the cycle after acceptance.
- SHAKE128, 200 bytes with random tvalid gaps → block1 = bytes 0..167 (is_last=0); block2 = bytes 168..199, byte32=1F, byte167=80.
- rst asserted mid-FILL (word_cnt=7) → all outputs 0 immediately, state IDLE; a following SHA3_start message packs from byte 0 correctly.
